// File: rtl/qs_pkg.sv
`default_nettype none
//==============================================================================
// Module      : qs_pkg
// Description : Shared constants and types for the sort-result collector:
//               register offsets, STATUS bit positions, read FSM states and
//               the value returned for unmapped addresses.
// Revision    : 1.0 - initial release
//==============================================================================
package qs_pkg;

    // Register byte offsets (low 8 address bits)
    localparam logic [7:0] c_REG_STATUS    = 8'h00;
    localparam logic [7:0] c_REG_DATA      = 8'h04;
    localparam logic [7:0] c_REG_FRAME_LEN = 8'h08;

    // STATUS bit positions; [7:0] hold the FIFO word count
    localparam int c_ST_EMPTY      = 8;
    localparam int c_ST_FULL       = 9;
    localparam int c_ST_FRAME_DONE = 10;
    localparam int c_ST_UNDERFLOW  = 11;
    localparam int c_ST_OVERFLOW   = 12;
    localparam int c_ST_ORDER_ERR  = 13;

    // Returned for any address outside the register map
    localparam logic [31:0] c_DEFAULT_READ = 32'hDEAD_BEEF;

    // AXI-Lite read channel state machine
    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/qs_result_collector_if.sv
`default_nettype none
//==============================================================================
// Module      : qs_result_collector_if
// Description : Bundles the sorted AXI-Stream input, the AXI-Lite read
//               channel and the interrupt line of the result collector.
//               master = stream source / CPU side, slave = collector.
// Revision    : 1.0 - initial release
//==============================================================================
interface qs_result_collector_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;
    logic                   arvalid;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   arready;
    logic                   rvalid;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   rready;
    logic                   irq;

    modport master (
        output ss_tvalid, ss_tdata, ss_tlast, arvalid, araddr, rready,
        input  ss_tready, arready, rvalid, rdata, irq
    );

    modport slave (
        input  ss_tvalid, ss_tdata, ss_tlast, arvalid, araddr, rready,
        output ss_tready, arready, rvalid, rdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/qs_sync_fifo.sv
`default_nettype none
//==============================================================================
// Module      : qs_sync_fifo
// Description : Single-clock FIFO with registered count. Push and pop in the
//               same cycle move both pointers and leave the count unchanged;
//               a freshly pushed word becomes visible at the head one cycle
//               later (no write-to-read bypass).
// Revision    : 1.0 - initial release
//==============================================================================
module qs_sync_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         i_push,
    input  wire logic [pDATA_WIDTH-1:0]       i_push_data,
    input  wire logic                         i_pop,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [$clog2(pDEPTH):0]           o_count,
    output logic [pDATA_WIDTH-1:0]            o_head
);
    localparam int c_PTR_W = $clog2(pDEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
    logic [c_PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]     count_q,  count_d;
    logic                   do_push, do_pop;

    assign o_full  = (count_q == c_CNT_W'(pDEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop  & ~o_empty;

    // Next pointers (power-of-two depth wraps naturally) and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; storage itself needs no reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/qs_result_collector.sv
`default_nettype none
//==============================================================================
// Module      : qs_result_collector
// Description : Buffers sorted stream words in a FIFO and lets the CPU drain
//               them, plus read STATUS / FRAME_LEN, over an AXI-Lite read
//               channel. Sticky STATUS flags clear when a STATUS read
//               completes. Optional build macro QS_ORDER_CHECK_EN adds an
//               in-frame ascending-order checker reported in STATUS[13].
// Revision    : 1.0 - initial release
//==============================================================================
module qs_result_collector
    import qs_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16
) (
    input  wire logic              axis_clk,
    input  wire logic              axis_rst_n,
    qs_result_collector_if.slave   bus
);
    localparam int c_CNT_W = $clog2(pDEPTH) + 1;

    // FIFO interface
    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [c_CNT_W-1:0]     fifo_count;
    logic [pDATA_WIDTH-1:0] fifo_head;

    // Control/state registers
    logic                   ready_q;
    rd_state_e              state_q, state_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   status_rd_q, status_rd_d;
    logic                   frame_done_q, frame_done_d;
    logic                   underflow_q, underflow_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic [15:0]            frame_len_q, frame_len_d;

    logic        push, ar_fire, sticky_clr, underflow_set, order_err;
    logic [7:0]  rd_addr;
    logic [31:0] status_word;
    logic [15:0] frame_cnt_inc;
    logic        unused_addr_hi;

    assign bus.ss_tready = ready_q & ~fifo_full;
    assign bus.arready   = ready_q & (state_q == RD_IDLE);
    assign bus.rvalid    = (state_q == RD_RESP);
    assign bus.rdata     = rdata_q;
    assign bus.irq       = frame_done_q & ~fifo_empty;

    assign push           = bus.ss_tvalid & bus.ss_tready;
    assign ar_fire        = bus.arvalid & bus.arready;
    assign sticky_clr     = bus.rvalid & bus.rready & status_rd_q;
    assign rd_addr        = bus.araddr[7:0];
    assign unused_addr_hi = ^bus.araddr[pADDR_WIDTH-1:8];

    qs_sync_fifo #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pDEPTH      (pDEPTH)
    ) u_fifo (
        .clk         (axis_clk),
        .rst_n       (axis_rst_n),
        .i_push      (push),
        .i_push_data (bus.ss_tdata),
        .i_pop       (fifo_pop),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count),
        .o_head      (fifo_head)
    );

    // Live STATUS snapshot taken at address capture
    always_comb begin
        status_word                  = '0;
        status_word[7:0]             = 8'(fifo_count);
        status_word[c_ST_EMPTY]      = fifo_empty;
        status_word[c_ST_FULL]       = fifo_full;
        status_word[c_ST_FRAME_DONE] = frame_done_q;
        status_word[c_ST_UNDERFLOW]  = underflow_q;
        status_word[c_ST_OVERFLOW]   = overflow_q;
        status_word[c_ST_ORDER_ERR]  = order_err;
    end

    // Read FSM: capture in IDLE (DATA pops here), hold response in RESP
    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata_q;
        status_rd_d   = status_rd_q;
        fifo_pop      = 1'b0;
        underflow_set = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (ar_fire) begin
                    state_d     = RD_RESP;
                    status_rd_d = 1'b0;
                    case (rd_addr)
                        c_REG_STATUS: begin
                            rdata_d     = pDATA_WIDTH'(status_word);
                            status_rd_d = 1'b1;
                        end
                        c_REG_DATA: begin
                            if (fifo_empty) begin
                                rdata_d       = '0;
                                underflow_set = 1'b1;
                            end else begin
                                rdata_d  = fifo_head;
                                fifo_pop = 1'b1;
                            end
                        end
                        c_REG_FRAME_LEN: rdata_d = pDATA_WIDTH'(frame_len_q);
                        default:         rdata_d = pDATA_WIDTH'(c_DEFAULT_READ);
                    endcase
                end
            end
            RD_RESP: begin
                if (bus.rready) state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Frame length tracking and sticky flags (a same-cycle set beats clear)
    always_comb begin
        frame_cnt_inc = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
        frame_cnt_d   = frame_cnt_q;
        frame_len_d   = frame_len_q;
        if (push) begin
            if (bus.ss_tlast) begin
                frame_len_d = frame_cnt_inc;
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_inc;
            end
        end
        frame_done_d = (frame_done_q & ~sticky_clr) | (push & bus.ss_tlast);
        underflow_d  = (underflow_q  & ~sticky_clr) | underflow_set;
        overflow_d   = (overflow_q   & ~sticky_clr) | (bus.ss_tvalid & fifo_full);
    end

    // Control, response and status registers
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ready_q      <= 1'b0;
            state_q      <= RD_IDLE;
            rdata_q      <= '0;
            status_rd_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
            frame_cnt_q  <= '0;
            frame_len_q  <= '0;
        end else begin
            ready_q      <= 1'b1;
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            status_rd_q  <= status_rd_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_len_q  <= frame_len_d;
        end
    end

`ifdef QS_ORDER_CHECK_EN
    logic [pDATA_WIDTH-1:0] prev_q, prev_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   order_err_q, order_err_d;
    logic                   order_set;

    // Compare each push against the previous word of the same frame
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        order_set    = 1'b0;
        if (push) begin
            order_set    = prev_valid_q & (bus.ss_tdata < prev_q);
            prev_d       = bus.ss_tdata;
            prev_valid_d = ~bus.ss_tlast;
        end
        order_err_d = (order_err_q & ~sticky_clr) | order_set;
    end

    // Order-check registers
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            order_err_q  <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            order_err_q  <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qs_result_collector.sv
`default_nettype none
//==============================================================================
// Module      : tb_qs_result_collector
// Description : Self-checking bench for qs_result_collector: a vector table
//               for the basic frame/drain flow plus directed sequences for
//               backpressure, underflow, held responses, push/pop overlap,
//               order checking (QS_ORDER_CHECK_EN) and reset mid-read.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_qs_result_collector;
    import qs_pkg::*;

    localparam int OP_PUSH = 0;
    localparam int OP_READ = 1;
    localparam int OP_IRQ  = 2;

    typedef struct {
        int          op;
        logic [11:0] addr;
        logic [31:0] data;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    qs_result_collector_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus();

    qs_result_collector #(
        .pADDR_WIDTH (12),
        .pDATA_WIDTH (32),
        .pDEPTH      (16)
    ) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .bus        (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        int n = 0;
        bus.ss_tvalid = 1'b1;
        bus.ss_tdata  = d;
        bus.ss_tlast  = l;
        while (bus.ss_tready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("push");
        tick();
        bus.ss_tvalid = 1'b0;
        bus.ss_tlast  = 1'b0;
    endtask

    task automatic read_reg(input logic [11:0] a, output logic [31:0] d);
        int n = 0;
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        while (bus.arready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("arready");
        tick();
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("rvalid");
        d = bus.rdata;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        read_reg(a, d);
        check(name, d, exp);
    endtask

    // 17 words with tvalid held: fill, stall, one pop, 17th word slips in
    task automatic test_backpressure();
        int   acc = 0;
        int   cyc = 0;
        logic rdy;
        bus.ss_tvalid = 1'b1;
        bus.ss_tlast  = 1'b0;
        bus.ss_tdata  = 32'd1;
        while (acc < 16 && cyc < 100) begin
            rdy = bus.ss_tready;
            tick();
            if (rdy) begin acc++; bus.ss_tdata = 32'(acc + 1); end
            cyc++;
        end
        if (acc < 16) timeout("fill");
        check("bp_tready_full", {31'd0, bus.ss_tready}, 32'd0);
        tick();
        tick();
        check("bp_tready_stall", {31'd0, bus.ss_tready}, 32'd0);
        check_read("bp_status_full", 12'h000, 32'h0000_1210);
        // Manual DATA read so the tready edge can be observed
        bus.arvalid = 1'b1;
        bus.araddr  = 12'h004;
        tick();
        bus.arvalid = 1'b0;
        check("bp_tready_rise", {31'd0, bus.ss_tready}, 32'd1);
        check("bp_pop_word1", bus.rdata, 32'd1);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("bp_word17_taken", {31'd0, bus.ss_tready}, 32'd0);
        bus.ss_tvalid = 1'b0;
        check_read("bp_status_refull", 12'h000, 32'h0000_1210);
        for (int i = 2; i <= 17; i++)
            check_read($sformatf("bp_drain%0d", i), 12'h004, 32'(i));
    endtask

    // Response held for 5 cycles with rready low
    task automatic test_hold();
        push_word(32'hA1, 1'b0);
        push_word(32'hA2, 1'b0);
        bus.arvalid = 1'b1;
        bus.araddr  = 12'h004;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_rvalid%0d", i),  {31'd0, bus.rvalid},  32'd1);
            check($sformatf("hold_rdata%0d", i),   bus.rdata,            32'hA1);
            check($sformatf("hold_arready%0d", i), {31'd0, bus.arready}, 32'd0);
            tick();
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check_read("hold_one_pop", 12'h000, 32'h0000_0001);
        check_read("hold_next", 12'h004, 32'hA2);
    endtask

    // Push and pop on the same edge with three words buffered
    task automatic test_overlap();
        push_word(32'hB1, 1'b0);
        push_word(32'hB2, 1'b0);
        push_word(32'hB3, 1'b0);
        check_read("ov_count3", 12'h000, 32'h0000_0003);
        bus.arvalid   = 1'b1;
        bus.araddr    = 12'h004;
        bus.ss_tvalid = 1'b1;
        bus.ss_tdata  = 32'hB4;
        bus.ss_tlast  = 1'b0;
        tick();
        bus.arvalid   = 1'b0;
        bus.ss_tvalid = 1'b0;
        check("ov_oldest", bus.rdata, 32'hB1);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check_read("ov_count_kept", 12'h000, 32'h0000_0003);
        check_read("ov_d2", 12'h004, 32'hB2);
        check_read("ov_d3", 12'h004, 32'hB3);
        check_read("ov_d4", 12'h004, 32'hB4);
    endtask

    // Descending pair inside a frame, then a fresh ascending frame
    task automatic test_order();
        push_word(32'd5, 1'b0);
        push_word(32'd3, 1'b1);
        check("ord_irq", {31'd0, bus.irq}, 32'd1);
`ifdef QS_ORDER_CHECK_EN
        check_read("ord_status_err", 12'h000, 32'h0000_2402);
`else
        check_read("ord_status_noerr", 12'h000, 32'h0000_0402);
`endif
        push_word(32'd1, 1'b0);
        push_word(32'd2, 1'b0);
        check_read("ord_status_clean", 12'h000, 32'h0000_0004);
        check_read("ord_d5", 12'h004, 32'd5);
        check_read("ord_d3", 12'h004, 32'd3);
        check_read("ord_d1", 12'h004, 32'd1);
        check_read("ord_d2", 12'h004, 32'd2);
    endtask

    // Reset while a response is pending drops it and empties the FIFO
    task automatic test_reset_mid();
        push_word(32'h77, 1'b0);
        push_word(32'h78, 1'b0);
        bus.arvalid = 1'b1;
        bus.araddr  = 12'h004;
        tick();
        bus.arvalid = 1'b0;
        check("rst_mid_pending", {31'd0, bus.rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("rst_mid_rdata", bus.rdata, 32'd0);
        check("rst_mid_tready", {31'd0, bus.ss_tready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_read("rst_mid_status", 12'h000, 32'h0000_0100);
    endtask

    initial begin
        logic [31:0] d;
        bus.ss_tvalid = 1'b0;
        bus.ss_tdata  = '0;
        bus.ss_tlast  = 1'b0;
        bus.arvalid   = 1'b0;
        bus.araddr    = '0;
        bus.rready    = 1'b0;

        // Frame of ten words, register reads and full drain
        for (int i = 1; i <= 10; i++)
            vecs.push_back('{OP_PUSH, 12'h000, 32'(i), (i == 10), 32'h0});
        vecs.push_back('{OP_IRQ,  12'h000, 32'h0, 1'b0, 32'h1});
        vecs.push_back('{OP_READ, 12'h000, 32'h0, 1'b0, 32'h0000_040A});
        vecs.push_back('{OP_READ, 12'h008, 32'h0, 1'b0, 32'h0000_000A});
        vecs.push_back('{OP_IRQ,  12'h000, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{OP_READ, 12'h00C, 32'h0, 1'b0, 32'hDEAD_BEEF});
        for (int i = 1; i <= 10; i++)
            vecs.push_back('{OP_READ, 12'h004, 32'h0, 1'b0, 32'(i)});
        vecs.push_back('{OP_READ, 12'h000, 32'h0, 1'b0, 32'h0000_0100});

        // Reset state
        repeat (3) tick();
        check("rst_tready",  {31'd0, bus.ss_tready}, 32'd0);
        check("rst_arready", {31'd0, bus.arready},   32'd0);
        check("rst_rvalid",  {31'd0, bus.rvalid},    32'd0);
        check("rst_rdata",   bus.rdata,              32'd0);
        check("rst_irq",     {31'd0, bus.irq},       32'd0);
        rst_n = 1'b1;
        check("rel_tready_low", {31'd0, bus.ss_tready}, 32'd0);
        tick();
        check("rel_tready_high", {31'd0, bus.ss_tready}, 32'd1);

        for (int k = 0; k < vecs.size(); k++) begin
            case (vecs[k].op)
                OP_PUSH: push_word(vecs[k].data, vecs[k].last);
                OP_READ: begin
                    read_reg(vecs[k].addr, d);
                    check($sformatf("vec%0d_read", k), d, vecs[k].exp);
                end
                default: check($sformatf("vec%0d_irq", k), {31'd0, bus.irq}, vecs[k].exp);
            endcase
        end

        test_backpressure();
        check_read("uf_data", 12'h004, 32'h0000_0000);
        check_read("uf_status", 12'h000, 32'h0000_0900);
        check_read("uf_cleared", 12'h000, 32'h0000_0100);
        test_hold();
        test_overlap();
        test_order();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
